// File: rtl/ppu_pkg.sv
// Shared PPU types and constants for the OAM scanner and its sprite buffer.
package ppu_pkg;

   typedef enum logic {
      S_IDLE,
      S_SCAN
   } scan_state_e;

   typedef struct packed {
      logic [7:0] flags;
      logic [7:0] tile;
      logic [7:0] x;
      logic [7:0] y;
   } oam_entry_t;

   typedef struct packed {
      logic [5:0] idx;
      oam_entry_t ent;
   } spr_rec_t;

   localparam int unsigned OAM_ENTRIES = 40;
   localparam int unsigned MAX_SPRITES = 10;
   localparam int unsigned SCAN_WORDS  = 80;
   localparam int unsigned Y_OFFSET    = 16;
   localparam int unsigned SPR_W       = 38;

   // Line/Y compare is done in 9 bits so LY+16 and Y+H never wrap.
   function automatic logic in_window(input logic [7:0] ly, input logic [7:0] y,
                                      input logic tall);
      logic [8:0] line;
      logic [8:0] top;
      logic [8:0] h;
      line = {1'b0, ly} + 9'(Y_OFFSET);
      top  = {1'b0, y};
      h    = tall ? 9'd16 : 9'd8;
      return (line >= top) && (line < (top + h));
   endfunction

endpackage

// File: rtl/oam_sprite_buf.sv
// Selected-sprite storage: 10 x 38-bit registers, one write port,
// one combinational read port, cleared asynchronously on rstN.
module oam_sprite_buf
   import ppu_pkg::*;
(
   input  logic             clk,
   input  logic             rstN,
   input  logic             we_i,
   input  logic [3:0]       waddr_i,
   input  logic [SPR_W-1:0] wdata_i,
   input  logic [3:0]       raddr_i,
   output logic [SPR_W-1:0] rdata_o
);

   logic [SPR_W-1:0] mem_q [MAX_SPRITES];

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         for (int unsigned i = 0; i < MAX_SPRITES; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i && (waddr_i < 4'(MAX_SPRITES))) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = (raddr_i < 4'(MAX_SPRITES)) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/oam_scan.sv
// PPU mode-2 OAM scanner: reads 80 OAM words and keeps up to 10 sprites on LY.
// Build option: define OAM_SCAN_XZERO_REJECT_EN to reject entries with X = 0.
module oam_scan
   import ppu_pkg::*;
(
   input  logic        clk,
   input  logic        rstN,
   input  logic        START,
   input  logic [7:0]  LY,
   input  logic        OBJ_SIZE,
   output logic        OAM_RD,
   output logic [6:0]  OAM_ADDR,
   input  logic [15:0] OAM_DATA_in,
   output logic        BUSY,
   output logic        DONE,
   output logic [3:0]  SPR_COUNT,
   input  logic [3:0]  SPR_IDX,
   output logic [37:0] SPR_DATA
);

   // cnt_q = edges since START; word (cnt_q-1) is on OAM_DATA_in, so 80/81 are tail cycles.
   localparam logic [6:0] IssueEnd = 7'(SCAN_WORDS);
   localparam logic [6:0] DoneCnt  = 7'(SCAN_WORDS + 1);
   localparam logic [3:0] MaxSpr   = 4'(MAX_SPRITES);

   scan_state_e      state_q, state_d;
   logic [6:0]       cnt_q, cnt_d;
   logic [7:0]       ly_q, ly_d;
   logic             tall_q, tall_d;
   logic [7:0]       y_q, y_d;
   logic [7:0]       x_q, x_d;
   logic [3:0]       count_q, count_d;
   logic             done_q, done_d;
   logic [6:0]       word;
   logic             hit;
   logic             buf_we;
   spr_rec_t         buf_wdata;
   logic [SPR_W-1:0] buf_rdata;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ly_q    <= '0;
         tall_q  <= 1'b0;
         y_q     <= '0;
         x_q     <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ly_q    <= ly_d;
         tall_q  <= tall_d;
         y_q     <= y_d;
         x_q     <= x_d;
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      hit = in_window(ly_q, y_q, tall_q);
`ifdef OAM_SCAN_XZERO_REJECT_EN
      hit = hit && (x_q != '0);
`endif
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ly_d      = ly_q;
      tall_d    = tall_q;
      y_d       = y_q;
      x_d       = x_q;
      count_d   = count_q;
      done_d    = 1'b0;
      buf_we    = 1'b0;
      buf_wdata = '0;
      word      = cnt_q - 7'd1;
      unique case (state_q)
         S_IDLE: begin
            if (START) begin
               state_d = S_SCAN;
               cnt_d   = '0;
               ly_d    = LY;
               tall_d  = OBJ_SIZE;
               count_d = '0;
            end
         end
         S_SCAN: begin
            cnt_d = cnt_q + 7'd1;
            if ((cnt_q >= 7'd1) && (cnt_q <= IssueEnd)) begin
               if (!word[0]) begin
                  y_d = OAM_DATA_in[7:0];
                  x_d = OAM_DATA_in[15:8];
               end else if (hit && (count_q < MaxSpr)) begin
                  buf_we              = 1'b1;
                  buf_wdata.idx       = word[6:1];
                  buf_wdata.ent.flags = OAM_DATA_in[15:8];
                  buf_wdata.ent.tile  = OAM_DATA_in[7:0];
                  buf_wdata.ent.x     = x_q;
                  buf_wdata.ent.y     = y_q;
                  count_d             = count_q + 4'd1;
               end
            end
            if (cnt_q == DoneCnt) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   oam_sprite_buf u_buf (
      .clk     (clk),
      .rstN    (rstN),
      .we_i    (buf_we),
      .waddr_i (count_q),
      .wdata_i (buf_wdata),
      .raddr_i (SPR_IDX),
      .rdata_o (buf_rdata)
   );

   assign BUSY      = (state_q == S_SCAN);
   assign DONE      = done_q;
   assign OAM_RD    = (state_q == S_SCAN) && (cnt_q < IssueEnd);
   assign OAM_ADDR  = OAM_RD ? cnt_q : '0;
   assign SPR_COUNT = count_q;
   assign SPR_DATA  = (SPR_IDX < count_q) ? buf_rdata : '0;

endmodule

// File: tb/tb_oam_scan.sv
// Directed self-checking bench for oam_scan with a registered OAM memory model.
module tb_oam_scan;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        START = 1'b0;
   logic [7:0]  LY = '0;
   logic        OBJ_SIZE = 1'b0;
   logic        OAM_RD;
   logic [6:0]  OAM_ADDR;
   logic [15:0] OAM_DATA_in;
   logic        BUSY;
   logic        DONE;
   logic [3:0]  SPR_COUNT;
   logic [3:0]  SPR_IDX = '0;
   logic [37:0] SPR_DATA;

   logic [7:0]  oam [160];
   int          vectors = 0;
   int          miscompares = 0;
   int          edges;
   int          seen;

   oam_scan dut (
      .clk         (clk),
      .rstN        (rstN),
      .START       (START),
      .LY          (LY),
      .OBJ_SIZE    (OBJ_SIZE),
      .OAM_RD      (OAM_RD),
      .OAM_ADDR    (OAM_ADDR),
      .OAM_DATA_in (OAM_DATA_in),
      .BUSY        (BUSY),
      .DONE        (DONE),
      .SPR_COUNT   (SPR_COUNT),
      .SPR_IDX     (SPR_IDX),
      .SPR_DATA    (SPR_DATA)
   );

   always #5 clk = ~clk;

   // Read data appears the cycle after the strobe.
   always @(posedge clk) begin
      if (OAM_RD) OAM_DATA_in <= {oam[2*int'(OAM_ADDR)+1], oam[2*int'(OAM_ADDR)]};
      else        OAM_DATA_in <= '0;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [37:0] rec(input int idx, input logic [7:0] f, input logic [7:0] t,
                                       input logic [7:0] x, input logic [7:0] y);
      return {6'(idx), f, t, x, y};
   endfunction

   task automatic chk_spr(input string tag, input int sel, input logic [37:0] exp);
      SPR_IDX = 4'(sel);
      #1;
      chk(tag, 64'(SPR_DATA), 64'(exp));
   endtask

   task automatic clear_oam();
      for (int i = 0; i < 160; i++) oam[i] = '0;
   endtask

   task automatic set_entry(input int i, input logic [7:0] y, input logic [7:0] x,
                            input logic [7:0] t, input logic [7:0] f);
      oam[4*i]   = y;
      oam[4*i+1] = x;
      oam[4*i+2] = t;
      oam[4*i+3] = f;
   endtask

   task automatic fill_all_y16();
      for (int i = 0; i < 40; i++) set_entry(i, 8'd16, 8'(i + 1), 8'(i), 8'h00);
   endtask

   task automatic start_scan(input logic [7:0] ly, input logic sz);
      @(negedge clk);
      LY = ly;
      OBJ_SIZE = sz;
      START = 1'b1;
      @(posedge clk);
      #1;
      START = 1'b0;
   endtask

   // Called #1 after the accepting edge; counts edges until DONE, checking the read sequence.
   task automatic wait_done(input int restart_at, output int n_done);
      int bad;
      bad = 0;
      n_done = 0;
      if (OAM_RD !== 1'b1 || OAM_ADDR !== 7'd0 || BUSY !== 1'b1) bad++;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk);
         #1;
         START = 1'b0;
         if (DONE === 1'b1) begin
            n_done = n;
            break;
         end
         if (OAM_RD !== 1'(n < 80) || OAM_ADDR !== ((n < 80) ? 7'(n) : 7'd0) || BUSY !== 1'b1)
            bad++;
         if (n == restart_at) START = 1'b1;
      end
      chk("addr_seq", 64'(bad), 64'(0));
      chk("done_edge", 64'(n_done), 64'(82));
      chk("busy_at_done", 64'(BUSY), 64'(0));
   endtask

   initial begin
      clear_oam();
      #2;
      chk("rst_busy", 64'(BUSY), 64'(0));
      chk("rst_done", 64'(DONE), 64'(0));
      chk("rst_rd", 64'(OAM_RD), 64'(0));
      chk("rst_addr", 64'(OAM_ADDR), 64'(0));
      chk("rst_count", 64'(SPR_COUNT), 64'(0));
      chk_spr("rst_data", 0, '0);
      @(negedge clk);
      rstN = 1'b1;

      // single 8x8 hit on entry 0
      set_entry(0, 8'd16, 8'd8, 8'h42, 8'h80);
      start_scan(8'd0, 1'b0);
      wait_done(0, edges);
      chk("s1_count", 64'(SPR_COUNT), 64'(1));
      chk_spr("s1_spr0", 0, rec(0, 8'h80, 8'h42, 8'd8, 8'd16));
      chk_spr("s1_spr1", 1, '0);
      @(posedge clk);
      #1;
      chk("s1_done_pulse", 64'(DONE), 64'(0));
      chk("s1_idle_rd", 64'(OAM_RD), 64'(0));

      // 8x16 window edges: line 36, Y=20 just out, Y=21 and Y=36 in
      clear_oam();
      set_entry(3, 8'd20, 8'd10, 8'h01, 8'h00);
      set_entry(5, 8'd21, 8'd11, 8'h02, 8'h00);
      set_entry(7, 8'd36, 8'd12, 8'h03, 8'h10);
      start_scan(8'd20, 1'b1);
      wait_done(0, edges);
      chk("s2_count", 64'(SPR_COUNT), 64'(2));
      chk_spr("s2_spr0", 0, rec(5, 8'h00, 8'h02, 8'd11, 8'd21));
      chk_spr("s2_spr1", 1, rec(7, 8'h10, 8'h03, 8'd12, 8'd36));
      chk_spr("s2_spr2", 2, '0);

      // same OAM in 8x8: Y=21 drops out (36 >= 29)
      start_scan(8'd20, 1'b0);
      wait_done(0, edges);
      chk("s3_count", 64'(SPR_COUNT), 64'(1));
      chk_spr("s3_spr0", 0, rec(7, 8'h10, 8'h03, 8'd12, 8'd36));

      // no 8-bit wrap: LY=250 (line 266) vs Y=255, 8x16
      clear_oam();
      set_entry(9, 8'd255, 8'd1, 8'h04, 8'h00);
      start_scan(8'd250, 1'b1);
      wait_done(0, edges);
      chk("s4_count", 64'(SPR_COUNT), 64'(1));
      chk_spr("s4_spr0", 0, rec(9, 8'h00, 8'h04, 8'd1, 8'd255));

      // all 40 hit: capped at 10, lowest indices kept
      fill_all_y16();
      start_scan(8'd0, 1'b0);
      wait_done(0, edges);
      chk("s5_count", 64'(SPR_COUNT), 64'(10));
      chk_spr("s5_spr0", 0, rec(0, 8'h00, 8'd0, 8'd1, 8'd16));
      chk_spr("s5_spr9", 9, rec(9, 8'h00, 8'd9, 8'd10, 8'd16));
      chk_spr("s5_spr10", 10, '0);

      // X = 0 entry
      clear_oam();
      set_entry(2, 8'd16, 8'd0, 8'h55, 8'h01);
      start_scan(8'd0, 1'b0);
      wait_done(0, edges);
`ifdef OAM_SCAN_XZERO_REJECT_EN
      chk("s6_count", 64'(SPR_COUNT), 64'(0));
      chk_spr("s6_spr0", 0, '0);
`else
      chk("s6_count", 64'(SPR_COUNT), 64'(1));
      chk_spr("s6_spr0", 0, rec(2, 8'h01, 8'h55, 8'd0, 8'd16));
`endif

      // START while busy is ignored; START alongside DONE begins a new scan
      fill_all_y16();
      start_scan(8'd0, 1'b0);
      wait_done(10, edges);
      chk("s7_count", 64'(SPR_COUNT), 64'(10));
      clear_oam();
      set_entry(0, 8'd16, 8'd8, 8'h42, 8'h80);
      LY = 8'd0;
      OBJ_SIZE = 1'b0;
      START = 1'b1;
      @(posedge clk);
      #1;
      START = 1'b0;
      chk("s7_restart_busy", 64'(BUSY), 64'(1));
      chk("s7_restart_count", 64'(SPR_COUNT), 64'(0));
      chk("s7_restart_done", 64'(DONE), 64'(0));
      wait_done(0, edges);
      chk("s7b_count", 64'(SPR_COUNT), 64'(1));
      chk_spr("s7b_spr0", 0, rec(0, 8'h80, 8'h42, 8'd8, 8'd16));

      // reset 40 cycles into a scan
      fill_all_y16();
      start_scan(8'd0, 1'b0);
      repeat (39) @(posedge clk);
      #1;
      chk("s8_pre_count", 64'(SPR_COUNT), 64'(10));
      #2;
      rstN = 1'b0;
      #1;
      chk("s8_rst_busy", 64'(BUSY), 64'(0));
      chk("s8_rst_rd", 64'(OAM_RD), 64'(0));
      chk("s8_rst_addr", 64'(OAM_ADDR), 64'(0));
      chk("s8_rst_count", 64'(SPR_COUNT), 64'(0));
      chk("s8_rst_done", 64'(DONE), 64'(0));
      @(negedge clk);
      rstN = 1'b1;
      seen = 0;
      for (int n = 0; n < 100; n++) begin
         @(posedge clk);
         #1;
         if (DONE === 1'b1 || BUSY === 1'b1) seen++;
      end
      chk("s8_no_done", 64'(seen), 64'(0));
      start_scan(8'd0, 1'b0);
      wait_done(0, edges);
      chk("s8_count", 64'(SPR_COUNT), 64'(10));
      chk_spr("s8_spr9", 9, rec(9, 8'h00, 8'd9, 8'd10, 8'd16));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
